// File: rtl/collision_detector_pkg.sv
// Shared snake constants: playfield size, body length limit, coordinate width
// and the collision checker's state encoding.
package collision_detector_pkg;

    localparam int GRID_W  = 16;
    localparam int GRID_H  = 12;
    localparam int MAX_LEN = 127;
    localparam int COORD_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SCAN,
        REPORT
    } state_t;

endpackage

// File: rtl/collision_detector.sv
// Checks a freshly moved snake head against the walls, the apple and every body
// segment (read one per cycle from an external store), then pulses the result.
module collision_detector
    import collision_detector_pkg::*;
#(
    parameter int GRID_W  = collision_detector_pkg::GRID_W,
    parameter int GRID_H  = collision_detector_pkg::GRID_H,
    parameter int MAX_LEN = collision_detector_pkg::MAX_LEN,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               start,
    input  logic [COORD_W-1:0] headX,
    input  logic [COORD_W-1:0] headY,
    input  logic [COORD_W-1:0] appleX,
    input  logic [COORD_W-1:0] appleY,
    input  logic [LEN_W-1:0]   bodyLen,
    output logic [LEN_W-1:0]   bodyAddr,
    input  logic [COORD_W-1:0] bodyX,
    input  logic [COORD_W-1:0] bodyY,
    output logic               goodColl,
    output logic               badColl,
    output logic               done,
    output logic               busy
);

    state_t             state;
    state_t             nextState;
    logic [COORD_W-1:0] headXL;
    logic [COORD_W-1:0] headYL;
    logic [COORD_W-1:0] appleXL;
    logic [COORD_W-1:0] appleYL;
    logic [LEN_W-1:0]   lenL;
    logic [LEN_W-1:0]   index;
    logic               wallFlag;
    logic               appleFlag;
    logic               selfFlag;
    logic               wallNow;
    logic               segMatch;
    logic               lastSeg;
    logic               badNow;

    // Out-of-grid coordinates are a wall hit; widen by one bit so GRID_W=32 still works.
    assign wallNow  = ({1'b0, headXL} >= (COORD_W + 1)'(GRID_W)) ||
                      ({1'b0, headYL} >= (COORD_W + 1)'(GRID_H));
    assign segMatch = (bodyX == headXL) && (bodyY == headYL);
    assign lastSeg  = (index == lenL - LEN_W'(1));
    assign badNow   = wallFlag || selfFlag;

    assign bodyAddr = (state == SCAN) ? index : '0;
    assign busy     = (state != IDLE);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = CHECK;
            CHECK:   begin
                if (wallNow || lenL <= LEN_W'(1)) nextState = REPORT;
                else                              nextState = SCAN;
            end
            SCAN:    if (segMatch || lastSeg) nextState = REPORT;
            REPORT:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state     <= IDLE;
            headXL    <= '0;
            headYL    <= '0;
            appleXL   <= '0;
            appleYL   <= '0;
            lenL      <= '0;
            index     <= '0;
            wallFlag  <= 1'b0;
            appleFlag <= 1'b0;
            selfFlag  <= 1'b0;
            goodColl  <= 1'b0;
            badColl   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (start) begin
                        headXL    <= headX;
                        headYL    <= headY;
                        appleXL   <= appleX;
                        appleYL   <= appleY;
                        lenL      <= bodyLen;
                        wallFlag  <= 1'b0;
                        appleFlag <= 1'b0;
                        selfFlag  <= 1'b0;
                    end
                end
                CHECK: begin
                    wallFlag  <= wallNow;
                    appleFlag <= !wallNow && (headXL == appleXL) && (headYL == appleYL);
                    index     <= LEN_W'(1);
                end
                SCAN: begin
                    if (segMatch) selfFlag <= 1'b1;
                    else          index    <= index + LEN_W'(1);
                end
                default: ;
            endcase
            // Result pulses are registered off REPORT, so they land one edge after it.
            done     <= (state == REPORT);
            badColl  <= (state == REPORT) && badNow;
            goodColl <= (state == REPORT) && appleFlag && !badNow;
        end
    end

endmodule

// File: doc/collision_detector.md
COLLISION_DETECTOR -- requirements
Module: collision_detector

Interface
REQ-001 SHALL have parameter GRID_W, default 16, in-grid X range 0..GRID_W-1.
REQ-002 SHALL have parameter GRID_H, default 12, in-grid Y range 0..GRID_H-1.
REQ-003 SHALL have parameter MAX_LEN, default 127, maximum body length including head.
REQ-004 clk  input  1  rising-edge system clock; single clock domain.
REQ-005 nRst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse: head has moved, check it.
REQ-007 headX, headY  input  5 each  new head coordinate; out-of-grid values are legal and mean wall.
REQ-008 appleX, appleY  input  5 each  current apple coordinate.
REQ-009 bodyLen  input  7  segment count including head, range 1..MAX_LEN.
REQ-010 bodyAddr  output  7  body-store read index; 0 is head, 1..bodyLen-1 are body.
REQ-011 bodyX, bodyY  input  5 each  segment at bodyAddr, combinational same-cycle read.
REQ-012 goodColl  output  1  one-cycle pulse: apple eaten; drives the score tracker.
REQ-013 badColl  output  1  one-cycle pulse: wall or self hit; drives the score tracker.
REQ-014 done  output  1  one-cycle pulse at end of every check.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, CHECK, SCAN, REPORT.
REQ-017 In IDLE, start=1 SHALL latch headX/Y, appleX/Y and bodyLen, then go to CHECK; start=0 stays in IDLE.
REQ-018 start while busy=1 SHALL be ignored; no queuing.
REQ-019 CHECK SHALL flag wall if latched headX >= GRID_W or headY >= GRID_H, then go to REPORT.
REQ-020 CHECK with no wall SHALL set the apple flag when head equals apple (both coordinates).
REQ-021 After a CHECK with no wall: if bodyLen <= 1, go to REPORT; otherwise load index 1 and go to SCAN.
REQ-022 SCAN SHALL drive bodyAddr = index and compare bodyX/Y with the latched head, one segment per cycle.
REQ-023 In SCAN, a match SHALL set the self flag and go to REPORT immediately.
REQ-024 In SCAN, with no match at index bodyLen-1, SHALL go to REPORT; otherwise increment index.
REQ-025 bodyAddr SHALL be 0 outside SCAN.
REQ-026 REPORT SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 In REPORT, badColl = wall OR self flag.
REQ-028 In REPORT, goodColl = apple flag AND NOT badColl; bad has priority, and both SHALL never be high together.
REQ-029 goodColl, badColl and done SHALL be registered outputs, low in all states other than REPORT.
REQ-030 Latency, start accepted at edge N: wall or bodyLen=1 reports at N+2.
REQ-031 Latency with a full scan: report at N+bodyLen+1.
REQ-032 Latency with a self hit at index k: report at N+k+2.
REQ-033 Input changes after start is accepted SHALL NOT affect the check in progress.
REQ-034 Index arithmetic SHALL be 7-bit unsigned; bodyLen=MAX_LEN SHALL scan to index 126 without wrap.

Reset
REQ-035 nRst low SHALL asynchronously force IDLE and clear all flags, latches and index.
REQ-036 During reset: goodColl=0, badColl=0, done=0, busy=0, bodyAddr=0.
REQ-037 Reset mid-SCAN SHALL abort the check with no pulse emitted after release.

Structure
REQ-038 Shared snake package SHALL hold GRID_W, GRID_H, MAX_LEN, coordinate width (5) and the FSM state enum.
REQ-039 SHALL be a single module with no sub-modules; the body store is external.

Verification
REQ-040 Apple case: head(3,4), apple(3,4), bodyLen=4, body clear -> goodColl at N+5, done same cycle, badColl=0.
REQ-041 Wall case: head(16,2), apple(16,2) -> badColl only, at N+2, with no SCAN cycles.
REQ-042 Self hit: bodyLen=10, segment 5 equals head -> badColl at N+7; bodyAddr visits 1..5 only.
REQ-043 Re-trigger: start pulses during busy and inputs changed mid-scan -> single result matching the latched values.
REQ-044 Reset: nRst low at SCAN index 3 -> outputs 0 immediately; no pulse after release; next start runs normally.
REQ-045 Maximum length: bodyLen=127, no hit -> done at N+128, bodyAddr peaks at 126.
